// File: rtl/sm_hex_capture_pkg.sv
// Shared seven-segment definitions: glyph table, blank pattern and {g..a} bit order.
// The display encoder and the capture decoder both use seg_glyph so they cannot drift apart.
package sm_hex_capture_pkg;

    localparam int SEG_BIT_A = 0;
    localparam int SEG_BIT_B = 1;
    localparam int SEG_BIT_C = 2;
    localparam int SEG_BIT_D = 3;
    localparam int SEG_BIT_E = 4;
    localparam int SEG_BIT_F = 5;
    localparam int SEG_BIT_G = 6;

    // Active-low glyphs, bit 0 = segment a.
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h18;
    localparam logic [6:0] SEG_A     = 7'h08;
    localparam logic [6:0] SEG_B     = 7'h03;
    localparam logic [6:0] SEG_C     = 7'h46;
    localparam logic [6:0] SEG_D     = 7'h21;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_F     = 7'h0E;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    function automatic logic [6:0] seg_glyph(input logic [3:0] nibble);
        logic [6:0] g;
        case (nibble)
            4'h0: g = SEG_0;
            4'h1: g = SEG_1;
            4'h2: g = SEG_2;
            4'h3: g = SEG_3;
            4'h4: g = SEG_4;
            4'h5: g = SEG_5;
            4'h6: g = SEG_6;
            4'h7: g = SEG_7;
            4'h8: g = SEG_8;
            4'h9: g = SEG_9;
            4'hA: g = SEG_A;
            4'hB: g = SEG_B;
            4'hC: g = SEG_C;
            4'hD: g = SEG_D;
            4'hE: g = SEG_E;
            default: g = SEG_F;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/sm_seven_seg_decode.sv
// Combinational seven-segment decoder: active-low segments -> {legal, blank, nibble}.
module sm_seven_seg_decode
    import sm_hex_capture_pkg::*;
(
    input  logic [6:0] segments,
    output logic       legal,
    output logic       blank,
    output logic [3:0] nibble
);

    always_comb begin
        legal  = 1'b0;
        nibble = 4'h0;
        blank  = (segments == SEG_BLANK);
        for (int n = 0; n < 16; n++) begin
            if (segments == seg_glyph(4'(n))) begin
                legal  = 1'b1;
                nibble = 4'(n);
            end
        end
    end

endmodule

// File: rtl/sm_hex_capture.sv
// Reads back a multiplexed seven-segment display: waits for each digit to be stable,
// decodes it, reassembles the multi-digit value and flags blanks and illegal patterns.
module sm_hex_capture
    import sm_hex_capture_pkg::*;
#(
    parameter int DIGITS        = 8,
    parameter int STABLE_CYCLES = 4,
    localparam int IDXW         = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DIGITS-1:0]     anodes,
    input  logic [6:0]            segments,
    output logic [4*DIGITS-1:0]   value,
    output logic [DIGITS-1:0]     digit_valid,
    output logic                  frame_done,
    output logic                  pattern_error,
    output logic [IDXW-1:0]       err_digit
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);

    logic [DIGITS-1:0] s_an;
    logic [6:0]        s_seg;
    logic [CW-1:0]     cnt;
    logic [DIGITS-1:0] seen;

    logic              in_same;
    logic              in_selectable;
    logic              capture;
    logic [IDXW-1:0]   idx;
    logic [DIGITS-1:0] cap_bit;
    logic              dec_legal;
    logic              dec_blank;
    logic [3:0]        dec_nibble;

    // The incoming sample is compared with the one already registered, so the counter
    // tracks "registered sample equals the previous registered sample".
    assign in_same       = ({anodes, segments} == {s_an, s_seg});
    assign in_selectable = $onehot(~anodes);
    assign capture       = (cnt == CW'(STABLE_CYCLES - 1));

    always_comb begin
        idx = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (!s_an[i]) idx = IDXW'(i);
        end
    end

    assign cap_bit = capture ? (DIGITS'(1) << idx) : '0;

    sm_seven_seg_decode u_decode (
        .segments (s_seg),
        .legal    (dec_legal),
        .blank    (dec_blank),
        .nibble   (dec_nibble)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_an  <= '0;
            s_seg <= '0;
            cnt   <= '0;
        end else begin
            s_an  <= anodes;
            s_seg <= segments;
            if (in_same && in_selectable) begin
                if (cnt != CW'(STABLE_CYCLES)) cnt <= cnt + CW'(1);
            end else begin
                cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value         <= '0;
            digit_valid   <= '0;
            pattern_error <= 1'b0;
            err_digit     <= '0;
        end else begin
            pattern_error <= 1'b0;
            if (capture) begin
                if (dec_legal) begin
                    value[4*idx +: 4] <= dec_nibble;
                    digit_valid[idx]  <= 1'b1;
                end else begin
                    digit_valid[idx] <= 1'b0;
                    if (!dec_blank) begin
                        pattern_error <= 1'b1;
                        err_digit     <= idx;
                    end
                end
            end
        end
    end

    // A capture landing in the same cycle as the frame pulse starts the next mask.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seen       <= '0;
            frame_done <= 1'b0;
        end else if (&seen) begin
            seen       <= cap_bit;
            frame_done <= 1'b1;
        end else begin
            seen       <= seen | cap_bit;
            frame_done <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sm_hex_capture.sv
// Directed bench for sm_hex_capture: scans, blanks, illegal glyphs, glitches,
// multi-select, capture latency and mid-scan reset, against hand-computed values.
module tb_sm_hex_capture;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  anodes;
    logic [6:0]  segments;
    logic [31:0] value;
    logic [7:0]  digit_valid;
    logic        frame_done;
    logic        pattern_error;
    logic [2:0]  err_digit;

    int n_checks = 0;
    int n_errors = 0;
    int frame_cnt = 0;
    int perr_cnt  = 0;

    logic [31:0] exp_q[$];

    logic [6:0] glyph_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                   7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    sm_hex_capture #(.DIGITS(8), .STABLE_CYCLES(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .anodes        (anodes),
        .segments      (segments),
        .value         (value),
        .digit_valid   (digit_valid),
        .frame_done    (frame_done),
        .pattern_error (pattern_error),
        .err_digit     (err_digit)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish within time limit");
        $fatal(1, "timeout");
    end

    // pulse monitors, sampled on the falling edge
    always @(negedge clk) begin
        if (frame_done)    frame_cnt++;
        if (pattern_error) perr_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_value(input string tag);
        check(tag, value, exp_q.pop_front());
    endtask

    // driver tasks
    task automatic show(input int idx, input logic [6:0] seg, input int cycles);
        @(negedge clk);
        anodes   = ~(8'd1 << idx);
        segments = seg;
        repeat (cycles) @(posedge clk);
    endtask

    task automatic idle(input int cycles);
        @(negedge clk);
        anodes   = 8'hFF;
        segments = 7'h7F;
        repeat (cycles) @(posedge clk);
    endtask

    task automatic scan(input logic [31:0] v, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) show(i, glyph_tab[v[4*i +: 4]], 6);
    endtask

    initial begin
        rst_n    = 1'b0;
        anodes   = 8'hFF;
        segments = 7'h7F;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset value", value, 32'h0);
        check("reset digit_valid", {24'h0, digit_valid}, 32'h0);
        check("reset frame_done", {31'h0, frame_done}, 32'h0);
        check("reset pattern_error", {31'h0, pattern_error}, 32'h0);
        check("reset err_digit", {29'h0, err_digit}, 32'h0);
        rst_n = 1'b1;

        // full scan
        scan(32'h1234ABCD, 0, 7);
        idle(2);
        @(negedge clk);
        exp_q.push_back(32'h1234ABCD);
        check_value("scan value");
        check("scan digit_valid", {24'h0, digit_valid}, 32'hFF);
        check("scan frame count", frame_cnt, 1);
        check("scan pattern_error count", perr_cnt, 0);

        // blank on digit 3
        show(3, 7'h7F, 6);
        @(negedge clk);
        exp_q.push_back(32'h1234ABCD);
        check_value("blank value");
        check("blank digit_valid", {24'h0, digit_valid}, 32'hF7);
        check("blank pattern_error count", perr_cnt, 0);

        // illegal pattern on digit 5
        show(5, 7'h55, 6);
        @(negedge clk);
        exp_q.push_back(32'h1234ABCD);
        check_value("illegal value");
        check("illegal pattern_error count", perr_cnt, 1);
        check("illegal err_digit", {29'h0, err_digit}, 32'd5);
        check("illegal digit_valid", {24'h0, digit_valid}, 32'hD7);

        // glitch: short 0 then stable 1 on digit 0
        show(0, 7'h40, 2);
        @(negedge clk);
        exp_q.push_back(32'h1234ABCD);
        check_value("glitch mid value");
        show(0, 7'h79, 4);
        idle(3);
        @(negedge clk);
        exp_q.push_back(32'h1234ABC1);
        check_value("glitch value");
        check("glitch digit_valid", {24'h0, digit_valid}, 32'hD7);
        check("glitch pattern_error count", perr_cnt, 1);

        // three-cycle hold is one edge short of a capture
        show(1, 7'h06, 3);
        idle(3);
        @(negedge clk);
        exp_q.push_back(32'h1234ABC1);
        check_value("short hold value");

        // capture appears exactly after the fifth edge
        show(2, 7'h18, 4);
        @(negedge clk);
        exp_q.push_back(32'h1234ABC1);
        check_value("latency before");
        @(posedge clk);
        @(negedge clk);
        exp_q.push_back(32'h1234A9C1);
        check_value("latency after");
        idle(2);

        // two anodes low: not selectable
        @(negedge clk);
        anodes   = 8'hFC;
        segments = 7'h40;
        repeat (10) @(posedge clk);
        @(negedge clk);
        exp_q.push_back(32'h1234A9C1);
        check_value("multi-select value");
        check("multi-select digit_valid", {24'h0, digit_valid}, 32'hD7);
        check("multi-select pattern_error count", perr_cnt, 1);
        check("multi-select frame count", frame_cnt, 1);
        show(3, 7'h78, 6);
        @(negedge clk);
        exp_q.push_back(32'h123479C1);
        check_value("after multi-select value");
        check("after multi-select digit_valid", {24'h0, digit_valid}, 32'hDF);

        // reset mid-scan
        scan(32'h00000765, 0, 2);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset value", value, 32'h0);
        check("midreset digit_valid", {24'h0, digit_valid}, 32'h0);
        check("midreset err_digit", {29'h0, err_digit}, 32'h0);
        check("midreset pattern_error", {31'h0, pattern_error}, 32'h0);
        check("midreset frame_done", {31'h0, frame_done}, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        scan(32'hFEDC0987, 3, 7);
        idle(3);
        @(negedge clk);
        check("partial scan frame count", frame_cnt, 1);
        scan(32'hFEDC0987, 0, 2);
        idle(3);
        @(negedge clk);
        check("rescan frame count", frame_cnt, 2);
        exp_q.push_back(32'hFEDC0987);
        check_value("rescan value");
        check("rescan digit_valid", {24'h0, digit_valid}, 32'hFF);
        check("rescan pattern_error count", perr_cnt, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
